// File: rtl/ctrl_pkg.sv
// Shared control-path definitions: instruction geometry, opcode encoding and
// the field slice positions used by the deserializer and the request queue.
package ctrl_pkg;

  localparam int ADDRW   = 8;
  localparam int OPCODEW = 2;
  localparam int INSTRW  = OPCODEW + 2 * ADDRW;

  localparam int   OP_SEL_BIT = 0;
  localparam logic OP_AES     = 1'b0;
  localparam logic OP_SHA     = 1'b1;

  // Field MSB positions inside an INSTRW-bit instruction word
  localparam int OPCODE_MSB = INSTRW - 1;
  localparam int KEY_MSB    = 2 * ADDRW - 1;
  localparam int TEXT_MSB   = ADDRW - 1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; one flop pair per bit.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/instr_deserializer.sv
// Receives serial instruction frames from the CPU, assembles them into one
// instruction word and offers it to the request queue via valid/ready.
module instr_deserializer #(
  parameter int ADDRW   = ctrl_pkg::ADDRW,
  parameter int OPCODEW = ctrl_pkg::OPCODEW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               spi_sclk,
  input  logic               spi_cs_n,
  input  logic               spi_mosi,
  input  logic               ready_in,
  output logic               valid_out,
  output logic [OPCODEW-1:0] opcode,
  output logic [ADDRW-1:0]   key_addr,
  output logic [ADDRW-1:0]   text_addr,
  output logic               frame_err,
  output logic               overflow
);

  localparam int INSTRW = OPCODEW + 2 * ADDRW;
  localparam int CNTW   = $clog2(INSTRW + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    WAIT_CS = 2'd2
  } state_t;

  state_t state, state_next;

  logic sclk_s, cs_n_s, mosi_s;
  logic sclk_d, cs_n_d;
  logic sclk_rise, cs_rise, cs_fall;

  logic [CNTW-1:0]   cnt;
  // Only the first INSTRW-1 bits are stored; the final bit goes straight to hold
  logic [INSTRW-2:0] shreg;
  logic [INSTRW-1:0] hold;
  logic              extra_bits;

  logic shift_en, complete, cnt_clr;
  logic short_err, extra_err, extra_set, extra_clr;
  logic load, drop;

  sync_2ff #(.WIDTH(3)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({spi_sclk, spi_cs_n, spi_mosi}),
    .q     ({sclk_s, cs_n_s, mosi_s})
  );

  // Delayed copies for edge detection. cs_n_d resets low so a cs_n that is
  // already low when reset releases is not mistaken for a frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_d <= 1'b0;
      cs_n_d <= 1'b0;
    end else begin
      sclk_d <= sclk_s;
      cs_n_d <= cs_n_s;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_d;
  assign cs_rise   = cs_n_s & ~cs_n_d;
  assign cs_fall   = ~cs_n_s & cs_n_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every signal driven here gets a default first, so no path through the
  // case statement leaves one unassigned and infers a latch.
  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    complete   = 1'b0;
    cnt_clr    = 1'b0;
    short_err  = 1'b0;
    extra_err  = 1'b0;
    extra_set  = 1'b0;
    extra_clr  = 1'b0;
    unique case (state)
      IDLE: begin
        if (cs_fall) begin
          cnt_clr    = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        // A shift coincident with cs_n rising is taken before the cs_n check
        shift_en = sclk_rise;
        if (sclk_rise && cnt == CNTW'(INSTRW - 1)) begin
          complete   = 1'b1;
          state_next = cs_rise ? IDLE : WAIT_CS;
        end else if (cs_rise) begin
          short_err  = 1'b1;
          state_next = IDLE;
        end
      end
      WAIT_CS: begin
        if (cs_rise) begin
          extra_err  = extra_bits | sclk_rise;
          extra_clr  = 1'b1;
          state_next = IDLE;
        end else if (sclk_rise) begin
          extra_set = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A slot being emptied this cycle can be refilled in the same cycle
  assign load = complete & (~valid_out | ready_in);
  assign drop = complete & valid_out & ~ready_in;

  // NOTE: the shift and holding registers are reset along with the control
  // state because their contents appear directly on the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      shreg      <= '0;
      hold       <= '0;
      extra_bits <= 1'b0;
      valid_out  <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (cnt_clr)       cnt <= '0;
      else if (shift_en) cnt <= cnt + CNTW'(1);

      if (shift_en) shreg <= {shreg[INSTRW-3:0], mosi_s};

      if (extra_clr)      extra_bits <= 1'b0;
      else if (extra_set) extra_bits <= 1'b1;

      frame_err <= short_err | extra_err;
      overflow  <= drop;

      if (load) begin
        hold      <= {shreg, mosi_s};
        valid_out <= 1'b1;
      end else if (valid_out && ready_in) begin
        valid_out <= 1'b0;
      end
    end
  end

  assign opcode    = hold[INSTRW-1 -: OPCODEW];
  assign key_addr  = hold[2*ADDRW-1 -: ADDRW];
  assign text_addr = hold[ADDRW-1:0];

endmodule
